// File: rtl/peak_scan_ctrl.sv
// Frame sequencer for the N-lane max-finder: packs raster pixels into engine
// vectors, issues them, and folds the returned group maxima into a frame peak.
module peak_scan_ctrl #(
   parameter int P_DATA_WIDTH = 8,
   parameter int P_DATA_NUM   = 8,
   parameter int P_IMG_W      = 640,
   parameter int P_IMG_H      = 512
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst_n,
   input  logic                                 i_start,
   input  logic [P_DATA_WIDTH-1:0]              i_pix_data,
   input  logic                                 i_pix_valid,
   output logic                                 o_pix_ready,
   output logic [P_DATA_WIDTH*P_DATA_NUM-1:0]   o_eng_data,
   output logic                                 o_eng_valid,
   input  logic                                 i_eng_valid,
   input  logic [P_DATA_WIDTH-1:0]              i_eng_max_value,
   input  logic [$clog2(P_DATA_NUM)-1:0]        i_eng_max_index,
   output logic                                 o_busy,
   output logic                                 o_done,
   output logic [P_DATA_WIDTH-1:0]              o_peak_value,
   output logic [$clog2(P_IMG_W)-1:0]           o_peak_x,
   output logic [$clog2(P_IMG_H)-1:0]           o_peak_y
);

   localparam int LW = $clog2(P_DATA_NUM);
   localparam int XW = $clog2(P_IMG_W);
   localparam int YW = $clog2(P_IMG_H);
   localparam int VW = P_DATA_WIDTH * P_DATA_NUM;

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

   state_t          state, state_nxt;
   logic [LW-1:0]   lane_cnt;
   logic [XW-1:0]   x_cnt;
   logic [YW-1:0]   y_cnt;
   logic [XW-1:0]   tag_x;
   logic [YW-1:0]   tag_y;
   logic            pending;
   logic            first_res;
   logic [VW-1:0]   lane_buf;
   logic [VW-1:0]   lane_buf_nxt;
   logic            accept;
   logic            last_lane;
   logic            last_pix;
   logic            start_ok;
   logic            res_take;
   logic            peak_load;

   assign accept    = i_pix_valid & o_pix_ready;
   assign last_lane = (lane_cnt == LW'(P_DATA_NUM - 1));
   assign last_pix  = (x_cnt == XW'(P_IMG_W - 1)) && (y_cnt == YW'(P_IMG_H - 1));
   assign start_ok  = (state == S_IDLE) && i_start;
   assign res_take  = i_eng_valid & pending;
   // The first result of a frame always loads, so an all-zero frame reports (0,0).
   assign peak_load = res_take & (first_res | (i_eng_max_value > o_peak_value));

   // Group vector including the pixel arriving this cycle, so lane N-1 issues without a bubble.
   always_comb begin
      lane_buf_nxt = lane_buf;
      lane_buf_nxt[int'(lane_cnt)*P_DATA_WIDTH +: P_DATA_WIDTH] = i_pix_data;
   end

   // NOTE: every signal assigned in an always_comb gets a default first, so no path infers a latch.
   always_comb begin
      state_nxt   = state;
      o_pix_ready = 1'b0;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_start) state_nxt = S_COLLECT;
         end
         S_COLLECT: begin
            o_pix_ready = 1'b1;
            o_busy      = 1'b1;
            if (accept && last_pix) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            o_busy = 1'b1;
            if (!pending || res_take) state_nxt = S_DONE;
         end
         S_DONE: begin
            o_done    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lane_cnt     <= '0;
         x_cnt        <= '0;
         y_cnt        <= '0;
         tag_x        <= '0;
         tag_y        <= '0;
         pending      <= 1'b0;
         first_res    <= 1'b0;
         lane_buf     <= '0;
         o_eng_data   <= '0;
         o_eng_valid  <= 1'b0;
         o_peak_value <= '0;
         o_peak_x     <= '0;
         o_peak_y     <= '0;
      end else begin
         o_eng_valid <= accept & last_lane;

         if (accept) begin
            lane_buf <= lane_buf_nxt;
            lane_cnt <= lane_cnt + LW'(1);
            if (x_cnt == XW'(P_IMG_W - 1)) begin
               x_cnt <= '0;
               y_cnt <= last_pix ? '0 : y_cnt + YW'(1);
            end else begin
               x_cnt <= x_cnt + XW'(1);
            end
            if (last_lane) begin
               o_eng_data <= lane_buf_nxt;
               tag_x      <= x_cnt & ~XW'(P_DATA_NUM - 1);
               tag_y      <= y_cnt;
               pending    <= 1'b1;
            end
         end

         // A result always lands before the next issue, so one tag register is enough.
         if (res_take) begin
            pending <= 1'b0;
            if (peak_load) begin
               first_res    <= 1'b0;
               o_peak_value <= i_eng_max_value;
               o_peak_x     <= tag_x + XW'(i_eng_max_index);
               o_peak_y     <= tag_y;
            end
         end

         if (start_ok) begin
            lane_cnt     <= '0;
            x_cnt        <= '0;
            y_cnt        <= '0;
            first_res    <= 1'b1;
            o_peak_value <= '0;
            o_peak_x     <= '0;
            o_peak_y     <= '0;
         end
      end
   end

endmodule

// File: tb/tb_peak_scan_ctrl.sv
// Directed bench for peak_scan_ctrl on a 16x2 frame with 4-lane groups; a
// behavioural engine answers each issue one cycle later.
module tb_peak_scan_ctrl;

   localparam int DW   = 8;
   localparam int N    = 4;
   localparam int IW   = 16;
   localparam int IH   = 2;
   localparam int NPIX = IW * IH;
   localparam int NGRP = NPIX / N;

   logic           i_clk = 1'b0;
   logic           i_rst_n = 1'b1;
   logic           i_start = 1'b0;
   logic [DW-1:0]  i_pix_data = '0;
   logic           i_pix_valid = 1'b0;
   logic           o_pix_ready;
   logic [DW*N-1:0] o_eng_data;
   logic           o_eng_valid;
   logic           i_eng_valid;
   logic [DW-1:0]  i_eng_max_value;
   logic [1:0]     i_eng_max_index;
   logic           o_busy;
   logic           o_done;
   logic [DW-1:0]  o_peak_value;
   logic [3:0]     o_peak_x;
   logic [0:0]     o_peak_y;

   logic           mdl_valid = 1'b0;
   logic [DW-1:0]  mdl_val = '0;
   logic [1:0]     mdl_idx = '0;
   logic           spur_valid = 1'b0;
   logic [DW-1:0]  spur_val = '0;
   logic [1:0]     spur_idx = '0;
   logic           resp_due = 1'b0;
   logic [DW-1:0]  resp_val = '0;
   logic [1:0]     resp_idx = '0;

   assign i_eng_valid     = mdl_valid | spur_valid;
   assign i_eng_max_value = spur_valid ? spur_val : mdl_val;
   assign i_eng_max_index = spur_valid ? spur_idx : mdl_idx;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int issue_cnt = 0;
   int issue_base = 0;
   int done_cnt = 0;
   int done_base = 0;
   logic [DW-1:0] pix_mem [NPIX];

   peak_scan_ctrl #(
      .P_DATA_WIDTH(DW),
      .P_DATA_NUM  (N),
      .P_IMG_W     (IW),
      .P_IMG_H     (IH)
   ) dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_start        (i_start),
      .i_pix_data     (i_pix_data),
      .i_pix_valid    (i_pix_valid),
      .o_pix_ready    (o_pix_ready),
      .o_eng_data     (o_eng_data),
      .o_eng_valid    (o_eng_valid),
      .i_eng_valid    (i_eng_valid),
      .i_eng_max_value(i_eng_max_value),
      .i_eng_max_index(i_eng_max_index),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_peak_value   (o_peak_value),
      .o_peak_x       (o_peak_x),
      .o_peak_y       (o_peak_y)
   );

   initial forever #5 i_clk = ~i_clk;

   // One cycle: monitor at the falling edge, answer issues seen on the previous tick.
   task automatic tick();
      int g;
      logic [DW*N-1:0] exp_vec;
      @(negedge i_clk);
      cyc++;
      mdl_valid = resp_due;
      if (resp_due) begin
         mdl_val = resp_val;
         mdl_idx = resp_idx;
      end
      resp_due = 1'b0;
      if (o_done) done_cnt++;
      if (o_eng_valid) begin
         g = issue_cnt - issue_base;
         exp_vec = '0;
         if (g < NGRP)
            for (int k = 0; k < N; k++) exp_vec[k*DW +: DW] = pix_mem[g*N + k];
         total++;
         if (g >= NGRP || o_eng_data !== exp_vec) begin
            bad++;
            $display("FAIL eng_data group %0d: got %h want %h", g, o_eng_data, exp_vec);
         end
         resp_val = o_eng_data[DW-1:0];
         resp_idx = 2'd0;
         for (int k = 1; k < N; k++)
            if (o_eng_data[k*DW +: DW] > resp_val) begin
               resp_val = o_eng_data[k*DW +: DW];
               resp_idx = 2'(k);
            end
         resp_due = 1'b1;
         issue_cnt++;
      end
   endtask

   task automatic set_frame(input logic [DW-1:0] bg);
      for (int p = 0; p < NPIX; p++) pix_mem[p] = bg;
   endtask

   task automatic start_frame();
      issue_base = issue_cnt;
      done_base  = done_cnt;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic feed(input int p, output int acc);
      int n;
      i_pix_valid = 1'b1;
      i_pix_data  = pix_mem[p];
      n = 0;
      while (!o_pix_ready && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) begin
         total++;
         bad++;
         $display("FAIL pix_ready_timeout pixel %0d: got ready=0 want ready=1", p);
      end
      acc = cyc;
      tick();
   endtask

   task automatic run_frame(input string name, input bit gaps, input bit poke,
                            input logic [DW-1:0] ev, input logic [3:0] ex, input logic ey);
      int n;
      int first_acc;
      int last_acc;
      first_acc = 0;
      last_acc  = 0;
      start_frame();
      for (int p = 0; p < NPIX; p++) begin
         if (gaps)
            for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++) begin
               i_pix_valid = 1'b0;
               tick();
            end
         if (poke && p == 5) i_start = 1'b1;
         feed(p, last_acc);
         i_start = 1'b0;
         if (p == 0) first_acc = last_acc;
      end
      i_pix_valid = 1'b0;
      if (!gaps) begin
         total++;
         if (last_acc - first_acc !== NPIX - 1) begin
            bad++;
            $display("FAIL %s throughput: got %0d cycles want %0d", name, last_acc - first_acc, NPIX - 1);
         end
      end
      n = 0;
      while (!o_done && n < 20) begin
         tick();
         n++;
      end
      total++;
      if (o_done !== 1'b1) begin
         bad++;
         $display("FAIL %s done_timeout: got done=%b want 1", name, o_done);
      end
      total++;
      if (cyc - last_acc !== 3) begin
         bad++;
         $display("FAIL %s done_latency: got %0d want 3", name, cyc - last_acc);
      end
      total++;
      if (o_peak_value !== ev) begin
         bad++;
         $display("FAIL %s peak_value: got %0d want %0d", name, o_peak_value, ev);
      end
      total++;
      if (o_peak_x !== ex) begin
         bad++;
         $display("FAIL %s peak_x: got %0d want %0d", name, o_peak_x, ex);
      end
      total++;
      if (o_peak_y !== ey) begin
         bad++;
         $display("FAIL %s peak_y: got %0d want %0d", name, o_peak_y, ey);
      end
      if (poke) begin
         i_start = 1'b1;
         tick();
         i_start = 1'b0;
         total++;
         if (o_busy !== 1'b0 || o_pix_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s start_in_done: got busy=%b ready=%b want 0 0", name, o_busy, o_pix_ready);
         end
      end
      repeat (4) tick();
      total++;
      if (done_cnt - done_base !== 1) begin
         bad++;
         $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt - done_base);
      end
      total++;
      if (issue_cnt - issue_base !== NGRP) begin
         bad++;
         $display("FAIL %s issues: got %0d want %0d", name, issue_cnt - issue_base, NGRP);
      end
   endtask

   task automatic check_idle_outputs(input string name);
      total++;
      if ({o_pix_ready, o_busy, o_done, o_eng_valid} !== 4'b0) begin
         bad++;
         $display("FAIL %s ctrl: got %b want 0000", name, {o_pix_ready, o_busy, o_done, o_eng_valid});
      end
      total++;
      if (o_eng_data !== '0) begin
         bad++;
         $display("FAIL %s eng_data: got %h want 0", name, o_eng_data);
      end
      total++;
      if ({o_peak_value, o_peak_x, o_peak_y} !== '0) begin
         bad++;
         $display("FAIL %s peak: got %0d,%0d,%0d want 0,0,0", name, o_peak_value, o_peak_x, o_peak_y);
      end
   endtask

   task automatic frame_hot();
      set_frame(8'd10);
      pix_mem[1*IW + 13] = 8'd200;
   endtask

   task automatic frame_tie();
      set_frame(8'd0);
      pix_mem[0*IW + 2] = 8'd50;
      pix_mem[1*IW + 9] = 8'd50;
   endtask

   task automatic test_reset();
      int acc;
      tick();
      i_rst_n = 1'b0;
      repeat (2) tick();
      check_idle_outputs("reset_init");
      i_rst_n = 1'b1;
      tick();
      frame_hot();
      start_frame();
      for (int p = 0; p < 10; p++) feed(p, acc);
      i_rst_n = 1'b0;
      #1;
      check_idle_outputs("reset_mid");
      repeat (2) tick();
      i_rst_n = 1'b1;
      i_pix_valid = 1'b0;
      repeat (5) tick();
      total++;
      if (done_cnt !== done_base || o_busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_abandon: got done=%0d busy=%b want done=%0d busy=0", done_cnt, o_busy, done_base);
      end
      run_frame("reset_recover", 1'b0, 1'b0, 8'd200, 4'd13, 1'b1);
   endtask

   task automatic test_hot_spot();
      frame_hot();
      run_frame("hot_spot", 1'b0, 1'b0, 8'd200, 4'd13, 1'b1);
   endtask

   task automatic test_tie();
      frame_tie();
      run_frame("tie", 1'b0, 1'b0, 8'd50, 4'd2, 1'b0);
   endtask

   task automatic test_all_zero();
      set_frame(8'd0);
      run_frame("all_zero", 1'b0, 1'b0, 8'd0, 4'd0, 1'b0);
   endtask

   task automatic test_gaps();
      frame_hot();
      run_frame("gaps", 1'b1, 1'b0, 8'd200, 4'd13, 1'b1);
   endtask

   task automatic test_ignored_inputs();
      frame_tie();
      run_frame("start_poke", 1'b0, 1'b1, 8'd50, 4'd2, 1'b0);
      spur_val   = 8'd255;
      spur_idx   = 2'd3;
      spur_valid = 1'b1;
      tick();
      spur_valid = 1'b0;
      repeat (2) tick();
      total++;
      if (o_peak_value !== 8'd50 || o_peak_x !== 4'd2 || o_peak_y !== 1'b0) begin
         bad++;
         $display("FAIL spurious_eng: got %0d,%0d,%0d want 50,2,0", o_peak_value, o_peak_x, o_peak_y);
      end
   endtask

   initial begin
      test_reset();
      test_hot_spot();
      test_tie();
      test_all_zero();
      test_gaps();
      test_ignored_inputs();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
